// File: rtl/stream_mux_arb.sv
// Stream multiplexer: NCH valid/ready inputs into one registered output,
// selected by a fixed channel index or by a round-robin arbiter.
module stream_mux_arb #(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    localparam int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          xfer_cnt
);

    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      cnt_q, cnt_d;

    logic             slot;
    logic             gnt_vld;
    logic [SELW-1:0]  gnt_idx;
    logic             take;

    // Grant is purely combinational so mode/sel changes act in the same cycle.
    always_comb begin : grant_logic
        int k;
        // NOTE: every variable gets a default before any branch; otherwise
        // a path that skips an assignment infers a latch.
        gnt_vld = 1'b0;
        gnt_idx = '0;
        k       = 0;
        if (!mode) begin
            if (int'(sel) < NCH) begin
                gnt_vld = 1'b1;
                gnt_idx = sel;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                k = int'(ptr_q) + i;
                if (k >= NCH) k = k - NCH;
                if (!gnt_vld && in_valid[k]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SELW'(k);
                end
            end
        end
    end

    always_comb begin : handshake_logic
        slot     = !out_valid_q || out_ready;
        in_ready = '0;
        if (gnt_vld && slot && !rst) in_ready[gnt_idx] = 1'b1;
        take     = gnt_vld && slot && !rst && in_valid[gnt_idx];
    end

    always_comb begin : next_state
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        if (out_valid_q && out_ready) cnt_d = cnt_q + 16'd1;
        if (slot) out_valid_d = take;
        if (take) begin
            out_data_d = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
            out_ch_d   = gnt_idx;
            // Fixed-mode transfers leave the round-robin position untouched.
            if (mode) ptr_d = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Self-checking bench for stream_mux_arb: directed scenarios plus random
// traffic scored against a cycle-level behavioural model.
module tb_stream_mux_arb;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid, in_ready;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic           out_valid, out_ready;
    logic [15:0]    xfer_cnt;

    // Three-channel instance for the out-of-range select case.
    logic [3*W-1:0] in_data3;
    logic [2:0]     in_valid3, in_ready3;
    logic           mode3;
    logic [1:0]     sel3;
    logic [W-1:0]   out_data3;
    logic [1:0]     out_ch3;
    logic           out_valid3, out_ready3;
    logic [15:0]    xfer_cnt3;

    stream_mux_arb #(.WIDTH(W), .NCH(N)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
        .xfer_cnt(xfer_cnt)
    );

    stream_mux_arb #(.WIDTH(W), .NCH(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
        .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3),
        .xfer_cnt(xfer_cnt3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit     m_valid = 0;
    int     m_data  = 0;
    int     m_ch    = 0;
    int     m_ptr   = 0;
    int     m_cnt   = 0;
    bit     m_rst_seen = 0;

    function automatic int model_grant();
        if (!mode) return (int'(sel) < N) ? int'(sel) : -1;
        for (int i = 0; i < N; i++) begin
            if (in_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    // Advance one clock: score in_ready before the edge, outputs after it.
    task automatic step();
        int g;
        bit slot, take, hs;
        logic [N-1:0] exp_ready;
        #1;
        g = model_grant();
        slot = !m_valid || out_ready;
        exp_ready = '0;
        if (g >= 0 && slot && !rst) exp_ready[g] = 1'b1;
        n_checks++;
        if (in_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL in_ready @%0t: got %b expected %b", $time, in_ready, exp_ready);
        end
        take = (g >= 0) && exp_ready[g] && in_valid[g];
        hs   = m_valid && out_ready;
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0; m_cnt = 0;
            m_rst_seen = 1;
        end else begin
            if (hs) m_cnt = (m_cnt + 1) % 65536;
            if (slot) begin
                if (take) begin
                    m_valid = 1;
                    m_data  = int'(in_data[g*W +: W]);
                    m_ch    = g;
                    if (mode) m_ptr = (g + 1) % N;
                end else begin
                    m_valid = 0;
                end
            end
            m_rst_seen = 0;
        end
        #1;
        n_checks++;
        if (out_valid !== m_valid || xfer_cnt !== 16'(m_cnt)) begin
            n_fail++;
            $display("FAIL out_valid/xfer_cnt @%0t: got %b/%0d expected %b/%0d",
                     $time, out_valid, xfer_cnt, m_valid, m_cnt);
        end
        if (m_valid || m_rst_seen) begin
            n_checks++;
            if (out_data !== W'(m_data) || out_ch !== SW'(m_ch)) begin
                n_fail++;
                $display("FAIL out_data/out_ch @%0t: got %h/%0d expected %h/%0d",
                         $time, out_data, out_ch, m_data, m_ch);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = '1; mode = 1'b0; sel = '0; out_ready = 1'b1;
        in_data = 32'hDEADBEEF;
        step();
        step();
        n_checks++;
        if (in_ready !== 4'b0000 || out_valid !== 1'b0 || out_data !== 8'h00 || xfer_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b v=%b d=%h c=%0d expected 0000/0/00/0",
                     in_ready, out_valid, out_data, xfer_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_fixed();
        do_reset();
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = {8'h77, 8'h55, 8'h33, 8'h11};
        #1;
        n_checks++;
        if (in_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL fixed_ready: got %b expected 0100", in_ready);
        end
        step();
        n_checks++;
        if (out_data !== 8'h55 || out_ch !== 2'd2 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL fixed_out: got %h/%0d/%b expected 55/2/1", out_data, out_ch, out_valid);
        end
    endtask

    task automatic test_round_robin();
        int exp_ch [5] = '{0, 1, 2, 3, 0};
        do_reset();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (out_ch !== SW'(exp_ch[i]) || out_data !== W'(8'h10 + exp_ch[i])) begin
                n_fail++;
                $display("FAIL rr_seq[%0d]: got ch%0d/%h expected ch%0d/%h",
                         i, out_ch, out_data, exp_ch[i], 8'h10 + exp_ch[i]);
            end
        end
        n_checks++;
        if (xfer_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL rr_count: got %0d expected 4", xfer_cnt);
        end
    endtask

    task automatic test_rr_wrap();
        int exp_ch [3] = '{3, 1, 3};
        do_reset();
        mode = 1'b1; out_ready = 1'b1; in_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        in_valid = 4'b0010;
        step();
        in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_ch !== SW'(exp_ch[i]) || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_wrap[%0d]: got ch%0d v=%b expected ch%0d v=1",
                         i, out_ch, out_valid, exp_ch[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b1;
        in_data = {8'h00, 8'h00, 8'hA5, 8'h00};
        step();
        out_ready = 1'b0;
        in_data = {8'h00, 8'h00, 8'h5A, 8'h00};
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_data !== 8'hA5 || out_valid !== 1'b1 || in_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL hold[%0d]: got %h v=%b rdy=%b expected a5 v=1 rdy=0000",
                         i, out_data, out_valid, in_ready);
            end
        end
        out_ready = 1'b1; in_valid = 4'b0000;
        step();
        step();
        n_checks++;
        if (xfer_cnt !== 16'd1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release: got cnt=%0d v=%b expected cnt=1 v=0", xfer_cnt, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mode = 1'b1; in_valid = 4'b0100; out_ready = 1'b1;
        in_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        repeat (8) step();
        n_checks++;
        if (xfer_cnt !== 16'd7 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got cnt=%0d v=%b expected cnt=7 v=1", xfer_cnt, out_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (xfer_cnt !== 16'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got cnt=%0d v=%b expected cnt=0 v=0", xfer_cnt, out_valid);
        end
        in_valid = 4'b1111;
        step();
        n_checks++;
        if (out_ch !== 2'd0 || out_data !== 8'hD0) begin
            n_fail++;
            $display("FAIL post_reset_ptr: got ch%0d/%h expected ch0/d0", out_ch, out_data);
        end
    endtask

    task automatic test_nch3_out_of_range();
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b111; out_ready3 = 1'b1;
        in_data3 = {8'h3E, 8'h3D, 8'h3C};
        step();
        n_checks++;
        if (out_valid3 !== 1'b1 || out_data3 !== 8'h3C) begin
            n_fail++;
            $display("FAIL nch3_first: got v=%b %h expected v=1 3c", out_valid3, out_data3);
        end
        sel3 = 2'd3;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (in_ready3 !== 3'b000) begin
                n_fail++;
                $display("FAIL nch3_ready[%0d]: got %b expected 000", i, in_ready3);
            end
            step();
            n_checks++;
            if (out_valid3 !== 1'b0) begin
                n_fail++;
                $display("FAIL nch3_valid[%0d]: got %b expected 0", i, out_valid3);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            mode      = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) sel = SW'($urandom_range(0, N - 1));
            in_valid  = N'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
        in_data3 = '0; in_valid3 = '0; mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b1;
        test_reset();
        test_fixed();
        test_round_robin();
        test_rr_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_nch3_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
